// File: rtl/wrapper_pkg.sv
// Shared types and default sizing for the byte-serial packet buffer.
package wrapper_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IN_WAIT,
        IN_ACK,
        OUT_VALID,
        OUT_ACK
    } state_t;

endpackage

// File: rtl/wrapper_ctrl.sv
// Handshake FSM and read/write pointers for the packet buffer.
// Each output flag depends on the state alone.
module wrapper_ctrl
    import wrapper_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_ready,
    input  logic             got_data,
    output logic             wr_en,
    output logic [PTR_W-1:0] wptr,
    output logic [PTR_W-1:0] rptr,
    output logic             ready_for_input,
    output logic             data_accepted,
    output logic             buffer_ready
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IN_WAIT;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        wr_en   = 1'b0;
        case (state_q)
            IN_WAIT: begin
                if (data_ready) begin
                    wr_en   = 1'b1;
                    state_d = IN_ACK;
                end
            end
            IN_ACK: begin
                // Waiting for data_ready to drop keeps a held request to one byte.
                if (!data_ready) begin
                    if (wptr_q == LAST) begin
                        wptr_d  = '0;
                        state_d = OUT_VALID;
                    end else begin
                        wptr_d  = wptr_q + 1'b1;
                        state_d = IN_WAIT;
                    end
                end
            end
            OUT_VALID: begin
                if (got_data) begin
                    state_d = OUT_ACK;
                end
            end
            OUT_ACK: begin
                if (!got_data) begin
                    if (rptr_q == LAST) begin
                        rptr_d  = '0;
                        state_d = IN_WAIT;
                    end else begin
                        rptr_d  = rptr_q + 1'b1;
                        state_d = OUT_VALID;
                    end
                end
            end
            default: state_d = IN_WAIT;
        endcase
    end

    always_comb begin
        ready_for_input = (state_q == IN_WAIT);
        data_accepted   = (state_q == IN_ACK);
        buffer_ready    = (state_q == OUT_VALID);
    end

    assign wptr = wptr_q;
    assign rptr = rptr_q;

endmodule

// File: rtl/wrapper_buffer.sv
// Single-packet byte buffer: collects DEPTH bytes from a producer, then
// replays them in arrival order to a consumer.
module wrapper_buffer
    import wrapper_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_ready,
    input  logic             got_data,
    input  logic [WIDTH-1:0] Bus_in,
    output logic             data_accepted,
    output logic             buffer_ready,
    output logic             ready_for_input,
    output logic [WIDTH-1:0] Bus_out
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             wr_en;
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    wrapper_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ctrl (
        .clk             (clk),
        .rst             (rst),
        .data_ready      (data_ready),
        .got_data        (got_data),
        .wr_en           (wr_en),
        .wptr            (wptr),
        .rptr            (rptr),
        .ready_for_input (ready_for_input),
        .data_accepted   (data_accepted),
        .buffer_ready    (buffer_ready)
    );

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wptr] = Bus_in;
        end
    end

    // Storage is cleared on reset so Bus_out reads zero until a packet lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign Bus_out = mem_q[rptr];

endmodule

// File: tb/tb_wrapper_buffer.sv
// Directed bench for wrapper_buffer: packet fill/drain, held handshakes,
// wrong-phase inputs and mid-packet reset.
module tb_wrapper_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       data_ready;
    logic       got_data;
    logic [7:0] Bus_in;
    logic       data_accepted;
    logic       buffer_ready;
    logic       ready_for_input;
    logic [7:0] Bus_out;

    int checks   = 0;
    int failures = 0;
    int da_pulses = 0;
    logic da_prev = 1'b0;

    wrapper_buffer #(.WIDTH(8), .DEPTH(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .data_ready      (data_ready),
        .got_data        (got_data),
        .Bus_in          (Bus_in),
        .data_accepted   (data_accepted),
        .buffer_ready    (buffer_ready),
        .ready_for_input (ready_for_input),
        .Bus_out         (Bus_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (data_accepted && !da_prev) da_pulses++;
        da_prev = data_accepted;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_full);
        chk("pre_send_rfi", 32'(ready_for_input), 32'd1);
        Bus_in     = b;
        data_ready = 1'b1;
        step(1);
        chk("send_da", 32'(data_accepted), 32'd1);
        chk("send_rfi_low", 32'(ready_for_input), 32'd0);
        Bus_in = 8'hEE;
        step(2);
        data_ready = 1'b0;
        step(1);
        chk("send_da_drop", 32'(data_accepted), 32'd0);
        chk("send_br", 32'(buffer_ready), 32'(exp_full));
        chk("send_rfi", 32'(ready_for_input), 32'(!exp_full));
    endtask

    task automatic drain_byte(input logic [7:0] exp, input logic last);
        chk("drain_br", 32'(buffer_ready), 32'd1);
        chk("drain_bus", 32'(Bus_out), 32'(exp));
        got_data = 1'b1;
        step(1);
        chk("drain_br_low", 32'(buffer_ready), 32'd0);
        step(2);
        got_data = 1'b0;
        step(1);
        chk("drain_next_br", 32'(buffer_ready), 32'(!last));
        chk("drain_next_rfi", 32'(ready_for_input), 32'(last));
        if (!last) step(1);
    endtask

    initial begin
        rst        = 1'b1;
        data_ready = 1'b0;
        got_data   = 1'b0;
        Bus_in     = 8'h00;
        step(2);
        rst = 1'b0;
        chk("rst_rfi", 32'(ready_for_input), 32'd1);
        chk("rst_da", 32'(data_accepted), 32'd0);
        chk("rst_br", 32'(buffer_ready), 32'd0);
        chk("rst_bus", 32'(Bus_out), 32'd0);

        // First packet: 35, 0, 9, 0
        da_pulses = 0;
        send_byte(8'd35, 1'b0);
        send_byte(8'd0,  1'b0);
        send_byte(8'd9,  1'b0);
        send_byte(8'd0,  1'b1);
        chk("da_pulses", 32'(da_pulses), 32'd4);
        drain_byte(8'd35, 1'b0);
        drain_byte(8'd0,  1'b0);
        drain_byte(8'd9,  1'b0);
        drain_byte(8'd0,  1'b1);

        // data_ready held for 10 cycles takes one byte
        chk("held_wptr0", 32'(dut.wptr), 32'd0);
        Bus_in     = 8'hAA;
        data_ready = 1'b1;
        step(1);
        chk("held_wptr_still", 32'(dut.wptr), 32'd0);
        step(9);
        chk("held_da", 32'(data_accepted), 32'd1);
        chk("held_rfi", 32'(ready_for_input), 32'd0);
        data_ready = 1'b0;
        step(1);
        chk("held_wptr1", 32'(dut.wptr), 32'd1);
        chk("held_rfi_back", 32'(ready_for_input), 32'd1);

        // got_data during input phase is ignored
        got_data = 1'b1;
        step(2);
        got_data = 1'b0;
        step(1);
        chk("wp_in_rfi", 32'(ready_for_input), 32'd1);
        chk("wp_in_wptr", 32'(dut.wptr), 32'd1);
        chk("wp_in_rptr", 32'(dut.rptr), 32'd0);

        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);

        // data_ready during output phase is ignored
        Bus_in     = 8'hFF;
        data_ready = 1'b1;
        step(2);
        data_ready = 1'b0;
        step(1);
        chk("wp_out_br", 32'(buffer_ready), 32'd1);
        chk("wp_out_da", 32'(data_accepted), 32'd0);
        chk("wp_out_rptr", 32'(dut.rptr), 32'd0);
        chk("wp_out_wptr", 32'(dut.wptr), 32'd0);
        drain_byte(8'hAA, 1'b0);
        drain_byte(8'h11, 1'b0);
        drain_byte(8'h22, 1'b0);
        drain_byte(8'h33, 1'b1);

        // Reset after two bytes, mid-handshake on the second
        send_byte(8'd5, 1'b0);
        Bus_in     = 8'd6;
        data_ready = 1'b1;
        step(1);
        chk("mid_da", 32'(data_accepted), 32'd1);
        rst        = 1'b1;
        data_ready = 1'b0;
        step(1);
        rst = 1'b0;
        chk("rst2_rfi", 32'(ready_for_input), 32'd1);
        chk("rst2_da", 32'(data_accepted), 32'd0);
        chk("rst2_br", 32'(buffer_ready), 32'd0);
        chk("rst2_bus", 32'(Bus_out), 32'd0);
        chk("rst2_wptr", 32'(dut.wptr), 32'd0);

        send_byte(8'd1, 1'b0);
        send_byte(8'd2, 1'b0);
        send_byte(8'd3, 1'b0);
        send_byte(8'd4, 1'b1);
        drain_byte(8'd1, 1'b0);
        drain_byte(8'd2, 1'b0);
        drain_byte(8'd3, 1'b0);
        drain_byte(8'd4, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
